// File: rtl/alu_pkg.sv
// alu_pkg
// Shared encodings for the EX-stage ALU and its iterative multiply/divide
// engine: main-control aluop codes, R-type funct codes, the internal 4-bit
// command set and the multiply/divide sequencer states.
package alu_pkg;

    // aluop from the main control unit
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    // R-type funct field
    localparam logic [5:0] FUNCT_SLL   = 6'b000000;
    localparam logic [5:0] FUNCT_SRL   = 6'b000010;
    localparam logic [5:0] FUNCT_SRA   = 6'b000011;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_XOR   = 6'b100110;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU  = 6'b101011;

    // internal command codes (signedness of mult/div is carried separately)
    localparam logic [3:0] CMD_AND  = 4'b0000;
    localparam logic [3:0] CMD_OR   = 4'b0001;
    localparam logic [3:0] CMD_ADD  = 4'b0010;
    localparam logic [3:0] CMD_XOR  = 4'b0011;
    localparam logic [3:0] CMD_MFHL = 4'b0100;
    localparam logic [3:0] CMD_SUB  = 4'b0110;
    localparam logic [3:0] CMD_SLT  = 4'b0111;
    localparam logic [3:0] CMD_SLTU = 4'b1000;
    localparam logic [3:0] CMD_SLL  = 4'b1001;
    localparam logic [3:0] CMD_SRL  = 4'b1010;
    localparam logic [3:0] CMD_SRA  = 4'b1011;
    localparam logic [3:0] CMD_NOR  = 4'b1100;
    localparam logic [3:0] CMD_MULT = 4'b1101;
    localparam logic [3:0] CMD_DIV  = 4'b1110;

    // multiply/divide sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ITER = 2'b01,
        ST_FIX  = 2'b10
    } md_state_t;

endpackage

// File: rtl/alu_muldiv.sv
// alu_muldiv
// Iterative WIDTH-cycle multiply / restoring-divide engine working on operand
// magnitudes, with a final sign-fix cycle.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            load operands and begin (only honoured while idle)
//   is_div           1 = divide, 0 = multiply
//   is_signed        operands are two's complement
//   a, b             multiplicand/dividend and multiplier/divisor
//   busy             engine is not idle
//   done             high during the sign-fix cycle; hi/lo are valid then
//   hi, lo           product {hi,lo}, or remainder (hi) and quotient (lo)
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    md_state_t state, state_next;

    logic [CW-1:0]      count;
    logic               div_op;
    logic               neg_main;
    logic               neg_rem;
    logic               div_zero;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_fits;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo, rem;

    // Operand magnitudes; the most-negative value maps onto itself, which is
    // still the right unsigned magnitude.
    assign a_neg = is_signed & a[WIDTH-1];
    assign b_neg = is_signed & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: ITER lasts exactly WIDTH edges, FIX exactly one
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_ITER;
            ST_ITER: if (count == LAST) state_next = ST_FIX;
            ST_FIX:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // One iteration step. acc holds the running product (shift-add, LSB of
    // the low half is the next multiplier bit) or {remainder, quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_fits  = (div_shift >= {1'b0, opnd});
        div_rem   = div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_next  = {div_rem, acc[WIDTH-2:0], div_fits};
    end

    // Datapath registers: operands latched on start, acc stepped in ITER
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            div_op   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            a_raw    <= '0;
            opnd     <= '0;
            acc      <= '0;
        end else if (state == ST_IDLE && start) begin
            count    <= '0;
            div_op   <= is_div;
            neg_main <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= (b == '0);
            a_raw    <= a;
            if (is_div) begin
                opnd <= b_mag;
                acc  <= {{WIDTH{1'b0}}, a_mag};
            end else begin
                opnd <= a_mag;
                acc  <= {{WIDTH{1'b0}}, b_mag};
            end
        end else if (state == ST_ITER) begin
            count <= count + 1'b1;
            acc   <= div_op ? div_next : mul_next;
        end
    end

    // Sign fix. Divide by zero bypasses the array: quotient all ones, the
    // remainder is the raw dividend.
    always_comb begin
        prod_fix = neg_main ? -acc : acc;
        quo      = acc[WIDTH-1:0];
        rem      = acc[2*WIDTH-1:WIDTH];
        if (!div_op) begin
            hi = prod_fix[2*WIDTH-1:WIDTH];
            lo = prod_fix[WIDTH-1:0];
        end else if (div_zero) begin
            hi = a_raw;
            lo = '1;
        end else begin
            hi = neg_rem  ? -rem : rem;
            lo = neg_main ? -quo : quo;
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_FIX);

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// EX-stage ALU for the multicycle MIPS datapath. Decodes aluop/funct into a
// 4-bit command, executes single-cycle ops with one cycle of latency and hands
// mult/div to the iterative engine, which writes HI/LO.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   valid_in, ready_out   request handshake (accept on valid_in && ready_out)
//   aluop, funct, shamt   operation select and shift amount
//   a, b                  operands rs, rt
//   result, zero          registered result and result == 0
//   valid_out, illegal    one-cycle completion pulse and illegal-op flag
//   hi, lo                HI/LO registers
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter bit MD_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_in,
    output logic                     ready_out,
    input  logic [1:0]               aluop,
    input  logic [5:0]               funct,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    output logic [WIDTH-1:0]         result,
    output logic                     zero,
    output logic                     valid_out,
    output logic                     illegal,
    output logic [WIDTH-1:0]         hi,
    output logic [WIDTH-1:0]         lo
);

    logic [3:0]       cmd;
    logic             dec_illegal;
    logic             dec_signed;
    logic             dec_sel_hi;
    logic             accept;
    logic             md_op;
    logic             md_start;
    logic             md_busy;
    logic             md_done;
    logic [WIDTH-1:0] md_hi, md_lo;
    logic [WIDTH-1:0] alu_res;

    // Decode aluop/funct. With MD_EN = 0 the HI/LO functs decode as illegal.
    always_comb begin
        cmd         = CMD_AND;
        dec_illegal = 1'b0;
        dec_signed  = 1'b0;
        dec_sel_hi  = 1'b0;
        case (aluop)
            ALUOP_ADD: cmd = CMD_ADD;
            ALUOP_SUB: cmd = CMD_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_AND:               cmd = CMD_AND;
                    FUNCT_OR:                cmd = CMD_OR;
                    FUNCT_ADD, FUNCT_ADDU:   cmd = CMD_ADD;
                    FUNCT_SUB, FUNCT_SUBU:   cmd = CMD_SUB;
                    FUNCT_SLT:               cmd = CMD_SLT;
                    FUNCT_SLTU:              cmd = CMD_SLTU;
                    FUNCT_NOR:               cmd = CMD_NOR;
                    FUNCT_XOR:               cmd = CMD_XOR;
                    FUNCT_SLL:               cmd = CMD_SLL;
                    FUNCT_SRL:               cmd = CMD_SRL;
                    FUNCT_SRA:               cmd = CMD_SRA;
                    FUNCT_MULT, FUNCT_MULTU: begin
                        cmd         = CMD_MULT;
                        dec_signed  = (funct == FUNCT_MULT);
                        dec_illegal = !MD_EN;
                    end
                    FUNCT_DIV, FUNCT_DIVU: begin
                        cmd         = CMD_DIV;
                        dec_signed  = (funct == FUNCT_DIV);
                        dec_illegal = !MD_EN;
                    end
                    FUNCT_MFHI: begin
                        cmd         = CMD_MFHL;
                        dec_sel_hi  = 1'b1;
                        dec_illegal = !MD_EN;
                    end
                    FUNCT_MFLO: begin
                        cmd         = CMD_MFHL;
                        dec_illegal = !MD_EN;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign accept    = valid_in && ready_out;
    assign md_op     = !dec_illegal && (cmd == CMD_MULT || cmd == CMD_DIV);
    assign md_start  = accept && md_op;
    assign ready_out = !md_busy;

    // Single-cycle datapath; illegal ops produce 0
    always_comb begin
        alu_res = '0;
        case (cmd)
            CMD_AND:  alu_res = a & b;
            CMD_OR:   alu_res = a | b;
            CMD_XOR:  alu_res = a ^ b;
            CMD_NOR:  alu_res = ~(a | b);
            CMD_ADD:  alu_res = a + b;
            CMD_SUB:  alu_res = a - b;
            CMD_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            CMD_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            CMD_SLL:  alu_res = b << shamt;
            CMD_SRL:  alu_res = b >> shamt;
            CMD_SRA:  alu_res = $signed(b) >>> shamt;
            CMD_MFHL: alu_res = dec_sel_hi ? hi : lo;
            default:  alu_res = '0;
        endcase
        if (dec_illegal) begin
            alu_res = '0;
        end
    end

    // The engine only exists when multiply/divide is enabled
    generate
        if (MD_EN) begin : g_md
            alu_muldiv #(
                .WIDTH(WIDTH)
            ) u_muldiv (
                .clk      (clk),
                .rst_n    (rst_n),
                .start    (md_start),
                .is_div   (cmd == CMD_DIV),
                .is_signed(dec_signed),
                .a        (a),
                .b        (b),
                .busy     (md_busy),
                .done     (md_done),
                .hi       (md_hi),
                .lo       (md_lo)
            );
        end else begin : g_no_md
            assign md_busy = 1'b0;
            assign md_done = 1'b0;
            assign md_hi   = '0;
            assign md_lo   = '0;
        end
    endgenerate

    // Output registers. Engine completion and a new accept never coincide
    // because ready_out is low during the FIX cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            zero      <= 1'b1;
            valid_out <= 1'b0;
            illegal   <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            valid_out <= 1'b0;
            if (md_done) begin
                hi        <= md_hi;
                lo        <= md_lo;
                result    <= md_lo;
                zero      <= (md_lo == '0);
                illegal   <= 1'b0;
                valid_out <= 1'b1;
            end else if (accept && !md_op) begin
                result    <= alu_res;
                zero      <= (alu_res == '0);
                illegal   <= dec_illegal;
                valid_out <= 1'b1;
            end
        end
    end

endmodule
